id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32I core, plus load-use hazard detection.
- Captures decoded operands and control from decode and presents them to execute.
- Supplies the execute-stage rs1/rs2/rd indices consumed by the forwarding unit.
- Generates the load-use stall that freezes PC and IF/ID, and inserts a bubble into EX.

---
 rtl/core_pkg.sv | 54 +++++
 rtl/load_use_detect.sv | 27 ++
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I pipeline: control bundle, enums, widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } result_src_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    result_src_e result_src;
    logic        branch;
    logic        jump;
  } ctrl_t;

  // Bubble control: no architectural side effects of any kind.
  localparam ctrl_t CTRL_NOP = '{
    alu_op:     ALU_ADD,
    alu_src:    1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    reg_write:  1'b0,
    result_src: RES_ALU,
    branch:     1'b0,
    jump:       1'b0
  };

  localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EX whose rd is read by the instruction in decode.
// Latency: purely combinational.
// Backpressure: produces the stall; it consumes none.
//   ex_valid_i/ex_mem_read_i/ex_rd_i : instruction currently in EX
//   id_valid_i/id_rs1_i/id_rs2_i     : instruction currently in decode
//   load_use_o                       : hold PC and IF/ID, bubble EX
module load_use_detect
  import core_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              load_use_o
);

  logic w_ex_load;
  logic w_src_match;

  // A load to x0 produces nothing to wait for, even when decode reads x0.
  assign w_ex_load   = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0);
  assign w_src_match = (ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i);
  assign load_use_o  = w_ex_load & id_valid_i & w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection (optional perf counters
// under macro ID_EX_PERF_CNT_EN).
// Latency: one cycle decode -> ex_*; load_use_stall_o is combinational.
// Backpressure: stall_i holds the register; load-use bubbles EX and stalls upstream.
//   clk_i, rst_i (sync, active-high), stall_i, flush_i
//   id_*  : decoded instruction in      ex_* : registered instruction out
//   load_use_stall_o : hold PC and IF/ID this cycle
//   load_use_cnt_o, flush_cnt_o : saturating event counters (macro only)
module id_ex_stage
  import core_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  ctrl_t             id_ctrl_i,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output ctrl_t             ex_ctrl_o,
  output logic              load_use_stall_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       load_use_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  ctrl_t             r_ctrl;

  logic w_load_use;
  logic w_bubble;
  logic w_load;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (r_valid),
    .ex_mem_read_i (r_ctrl.mem_read),
    .ex_rd_i       (r_rd),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .load_use_o    (w_load_use)
  );

  // Flush beats hold; a hold keeps a pending load in EX, so the load-use
  // bubble is only inserted on the first edge without stall_i.
  assign w_bubble = flush_i | (~stall_i & w_load_use);
  assign w_load   = ~flush_i & ~stall_i & ~w_load_use;

  always_ff @(posedge clk_i) begin
    if (rst_i || w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= CTRL_NOP;
    end else if (w_load) begin
      r_valid    <= id_valid_i;
      r_pc       <= id_pc_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
      // An empty decode slot must never carry side-effecting control into EX.
      r_ctrl     <= id_valid_i ? id_ctrl_i : CTRL_NOP;
    end
  end

  assign ex_valid_o       = r_valid;
  assign ex_pc_o          = r_pc;
  assign ex_rs1_data_o    = r_rs1_data;
  assign ex_rs2_data_o    = r_rs2_data;
  assign ex_imm_o         = r_imm;
  assign ex_rs1_o         = r_rs1;
  assign ex_rs2_o         = r_rs2;
  assign ex_rd_o          = r_rd;
  assign ex_ctrl_o        = r_ctrl;
  assign load_use_stall_o = w_load_use;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_load_use_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_load_use_cnt <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (flush_i && (r_flush_cnt != PERF_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
      // Only the edge that actually inserts the load-use bubble counts.
      if (!flush_i && !stall_i && w_load_use && (r_load_use_cnt != PERF_CNT_MAX)) begin
        r_load_use_cnt <= r_load_use_cnt + 32'd1;
      end
    end
  end

  assign load_use_cnt_o = r_load_use_cnt;
  assign flush_cnt_o    = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import core_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
  } ex_t;

  typedef struct packed {
    logic              rst;
    logic              stall;
    logic              flush;
    logic              vld;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   d1;
    logic [XLEN-1:0]   d2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
  } stim_t;

  typedef struct packed {
    ex_t  ex;
    logic stall;
  } exp_t;

  logic              clk_i;
  logic              rst_i;
  logic              stall_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  ctrl_t             id_ctrl_i;
  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_pc_o;
  logic [XLEN-1:0]   ex_rs1_data_o;
  logic [XLEN-1:0]   ex_rs2_data_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [REG_AW-1:0] ex_rs1_o;
  logic [REG_AW-1:0] ex_rs2_o;
  logic [REG_AW-1:0] ex_rd_o;
  ctrl_t             ex_ctrl_o;
  logic              load_use_stall_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]       load_use_cnt_o;
  logic [31:0]       flush_cnt_o;
  logic [31:0]       m_lu_cnt;
  logic [31:0]       m_fl_cnt;
`endif

  int   total;
  int   bad;
  exp_t sb_q[$];
  ex_t  model;

  id_ex_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .id_valid_i       (id_valid_i),
    .id_pc_i          (id_pc_i),
    .id_rs1_data_i    (id_rs1_data_i),
    .id_rs2_data_i    (id_rs2_data_i),
    .id_imm_i         (id_imm_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_rd_i          (id_rd_i),
    .id_ctrl_i        (id_ctrl_i),
    .ex_valid_o       (ex_valid_o),
    .ex_pc_o          (ex_pc_o),
    .ex_rs1_data_o    (ex_rs1_data_o),
    .ex_rs2_data_o    (ex_rs2_data_o),
    .ex_imm_o         (ex_imm_o),
    .ex_rs1_o         (ex_rs1_o),
    .ex_rs2_o         (ex_rs2_o),
    .ex_rd_o          (ex_rd_o),
    .ex_ctrl_o        (ex_ctrl_o),
    .load_use_stall_o (load_use_stall_o)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .load_use_cnt_o   (load_use_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  function automatic ex_t empty_ex();
    ex_t e;
    e      = '0;
    e.ctrl = CTRL_NOP;
    return e;
  endfunction

  // Decode needs the value a load in EX has not fetched yet (x0 is constant).
  function automatic logic needs_wait(ex_t e, stim_t s);
    if (!e.valid || !e.ctrl.mem_read || e.rd == '0 || !s.vld) return 1'b0;
    return (s.rs1 == e.rd) || (s.rs2 == e.rd);
  endfunction

  function automatic ex_t from_decode(stim_t s);
    ex_t e;
    e.valid    = s.vld;
    e.pc       = s.pc;
    e.rs1_data = s.d1;
    e.rs2_data = s.d2;
    e.imm      = s.imm;
    e.rs1      = s.rs1;
    e.rs2      = s.rs2;
    e.rd       = s.rd;
    e.ctrl     = s.vld ? s.ctrl : CTRL_NOP;
    return e;
  endfunction

  function automatic ex_t next_ex(ex_t cur, stim_t s);
    if (s.rst)             return empty_ex();
    if (s.flush)           return empty_ex();
    if (s.stall)           return cur;
    if (needs_wait(cur, s)) return empty_ex();
    return from_decode(s);
  endfunction

  // ---------------- stimulus ----------------
  function automatic stim_t rnd_stim();
    stim_t s;
    logic [$bits(ctrl_t)-1:0] cb;
    cb      = $bits(ctrl_t)'($urandom);
    s.rst   = ($urandom_range(0, 59) == 0);
    s.stall = ($urandom_range(0, 5) == 0);
    s.flush = ($urandom_range(0, 7) == 0);
    s.vld   = ($urandom_range(0, 7) != 0);
    s.pc    = $urandom;
    s.d1    = $urandom;
    s.d2    = $urandom;
    s.imm   = $urandom;
    // Small index range so register collisions (and x0) are frequent.
    s.rs1   = REG_AW'($urandom_range(0, 7));
    s.rs2   = REG_AW'($urandom_range(0, 7));
    s.rd    = REG_AW'($urandom_range(0, 7));
    s.ctrl  = cb;
    return s;
  endfunction

  function automatic stim_t mk(input logic rst, input logic stall, input logic flush,
                               input logic vld, input logic [XLEN-1:0] pc,
                               input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                               input logic [REG_AW-1:0] rd, input logic ld);
    stim_t s;
    s                 = rnd_stim();
    s.rst             = rst;
    s.stall           = stall;
    s.flush           = flush;
    s.vld             = vld;
    s.pc              = pc;
    s.rs1             = rs1;
    s.rs2             = rs2;
    s.rd              = rd;
    s.ctrl            = CTRL_NOP;
    s.ctrl.reg_write  = 1'b1;
    s.ctrl.mem_read   = ld;
    s.ctrl.alu_src    = ld;
    s.ctrl.result_src = ld ? RES_MEM : RES_ALU;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst_i         = s.rst;
    stall_i       = s.stall;
    flush_i       = s.flush;
    id_valid_i    = s.vld;
    id_pc_i       = s.pc;
    id_rs1_data_i = s.d1;
    id_rs2_data_i = s.d2;
    id_imm_i      = s.imm;
    id_rs1_i      = s.rs1;
    id_rs2_i      = s.rs2;
    id_rd_i       = s.rd;
    id_ctrl_i     = s.ctrl;
  endtask

  // Drive one cycle: record what the DUT must show this cycle, then advance the model.
  task automatic cycle(input stim_t s);
    exp_t e;
    apply(s);
    #1;
    e.ex    = model;
    e.stall = needs_wait(model, s);
    sb_q.push_back(e);
`ifdef ID_EX_PERF_CNT_EN
    if (s.rst) begin
      m_lu_cnt = '0;
      m_fl_cnt = '0;
    end else if (s.flush) begin
      if (m_fl_cnt != 32'hFFFF_FFFF) m_fl_cnt = m_fl_cnt + 1;
    end else if (!s.stall && e.stall) begin
      if (m_lu_cnt != 32'hFFFF_FFFF) m_lu_cnt = m_lu_cnt + 1;
    end
`endif
    model = next_ex(model, s);
    @(posedge clk_i);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    ex_t  act;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() != 0) begin
        e            = sb_q.pop_front();
        act.valid    = ex_valid_o;
        act.pc       = ex_pc_o;
        act.rs1_data = ex_rs1_data_o;
        act.rs2_data = ex_rs2_data_o;
        act.imm      = ex_imm_o;
        act.rs1      = ex_rs1_o;
        act.rs2      = ex_rs2_o;
        act.rd       = ex_rd_o;
        act.ctrl     = ex_ctrl_o;
        total++;
        if (act !== e.ex) begin
          bad++;
          $display("FAIL ex_state t=%0t got=%h want=%h", $time, act, e.ex);
        end
        total++;
        if (load_use_stall_o !== e.stall) begin
          bad++;
          $display("FAIL load_use_stall t=%0t got=%b want=%b", $time, load_use_stall_o, e.stall);
        end
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    stim_t s;
    logic  hold;
    total = 0;
    bad   = 0;
    model = empty_ex();
`ifdef ID_EX_PERF_CNT_EN
    m_lu_cnt = '0;
    m_fl_cnt = '0;
`endif
    // Reset for two cycles with random inputs; the first edge defines state.
    s = rnd_stim(); s.rst = 1'b1;
    apply(s);
    @(posedge clk_i);
    #2;
    s = rnd_stim(); s.rst = 1'b1;
    cycle(s);

    // add x3,x1,x2 @0x100 passes straight through
    cycle(mk(0, 0, 0, 1, 32'h100, 5'd1, 5'd2, 5'd3, 0));
    // lw x5 then add x6,x5,x7: one stall cycle, bubble, then the add
    cycle(mk(0, 0, 0, 1, 32'h104, 5'd1, 5'd0, 5'd5, 1));
    cycle(mk(0, 0, 0, 1, 32'h108, 5'd5, 5'd7, 5'd6, 0));
    cycle(mk(0, 0, 0, 1, 32'h108, 5'd5, 5'd7, 5'd6, 0));
    cycle(mk(0, 0, 0, 0, 32'h10C, 5'd0, 5'd0, 5'd0, 0));
    // lw x0 followed by a reader of x0: no stall
    cycle(mk(0, 0, 0, 1, 32'h110, 5'd2, 5'd0, 5'd0, 1));
    cycle(mk(0, 0, 0, 1, 32'h114, 5'd0, 5'd0, 5'd4, 0));
    // flush together with stall: bubble
    cycle(mk(0, 1, 1, 1, 32'h118, 5'd1, 5'd2, 5'd8, 0));
    // stall alone for three cycles: EX unchanged
    cycle(mk(0, 0, 0, 1, 32'h11C, 5'd1, 5'd2, 5'd8, 0));
    repeat (3) cycle(mk(0, 1, 0, 1, 32'h120, 5'd3, 5'd4, 5'd9, 0));
    // load-use coinciding with flush
    cycle(mk(0, 0, 0, 1, 32'h124, 5'd1, 5'd0, 5'd9, 1));
    cycle(mk(0, 0, 1, 1, 32'h128, 5'd2, 5'd9, 5'd10, 0));
    // load-use held by stall_i, then a single bubble
    cycle(mk(0, 0, 0, 1, 32'h12C, 5'd1, 5'd0, 5'd9, 1));
    repeat (2) cycle(mk(0, 1, 0, 1, 32'h130, 5'd9, 5'd2, 5'd11, 0));
    repeat (2) cycle(mk(0, 0, 0, 1, 32'h130, 5'd9, 5'd2, 5'd11, 0));
    // reset in the middle of a load-use stall
    cycle(mk(0, 0, 0, 1, 32'h134, 5'd1, 5'd0, 5'd9, 1));
    cycle(mk(1, 0, 0, 1, 32'h138, 5'd9, 5'd9, 5'd12, 0));
    cycle(mk(0, 0, 0, 1, 32'h138, 5'd9, 5'd9, 5'd12, 0));

    // Random traffic; decode is held whenever the pipe upstream would be frozen.
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      stim_t n;
      n = rnd_stim();
      if (hold) begin
        n.vld  = s.vld;  n.pc  = s.pc;  n.d1 = s.d1; n.d2 = s.d2; n.imm = s.imm;
        n.rs1  = s.rs1;  n.rs2 = s.rs2; n.rd = s.rd; n.ctrl = s.ctrl;
      end
      s    = n;
      hold = !s.rst && !s.flush && (s.stall || needs_wait(model, s));
      cycle(s);
    end

    // Freeze the DUT while the last expectations drain.
    rst_i   = 1'b0;
    flush_i = 1'b0;
    stall_i = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk_i);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
`ifdef ID_EX_PERF_CNT_EN
    total++;
    if (load_use_cnt_o !== m_lu_cnt) begin
      bad++;
      $display("FAIL load_use_cnt got=%0d want=%0d", load_use_cnt_o, m_lu_cnt);
    end
    total++;
    if (flush_cnt_o !== m_fl_cnt) begin
      bad++;
      $display("FAIL flush_cnt got=%0d want=%0d", flush_cnt_o, m_fl_cnt);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
